adc_readout_ctrl: RTL and testbench

Parametrised control/readout sequencer between N_CHAN ADC deserialiser channels (show-ahead sample FIFOs, N_LANE lanes each) and the 32-bit control bus. Provides a channel-enable mask, run control and channel/lane select. Sample pop is lane-sequenced and non-destructive until the last lane is read. Adds a saturating sample counter and sticky bus-error flags.

---
 rtl/adc_readout_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_adc_readout_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_readout_ctrl.sv
// ---------------------------------------------------------------------------
// adc_readout_ctrl
//   Control/readout sequencer between N_CHAN ADC deserialiser channels and a
//   32-bit control bus. It holds the run/enable/select registers, drives the
//   per-channel capture enables, and returns FIFO head samples one lane at a
//   time. The FIFO word is popped only after its last lane has been read.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-high
//   write_req     bus write strobe (single cycle)
//   read_req      bus read strobe (single cycle)
//   data_write    bus write data
//   data_read     registered bus read data
//   addr          word address, only addr[2:0] decoded
//   busy          high while a bus operation is in progress
//   read_enable   per-channel deserialiser capture enable (chan_en & run)
//   buffer_rdreq  per-channel FIFO pop pulse
//   buffer_empty  per-channel FIFO empty flag
//   buffer_data   show-ahead head words, channel c lane l at
//                 [(c*N_LANE+l)*SAMPLE_W +: SAMPLE_W]
//
// State table:
//   IDLE     | waiting for a bus request
//   REG_ACK  | register access done, busy for one cycle
//   DATA_CHK | validate selected channel, capture lane sample
//   DATA_POP | pop the selected FIFO after its last lane was read
//   ACK      | data read done, return to IDLE
// ---------------------------------------------------------------------------
module adc_readout_ctrl #(
  parameter int N_CHAN   = 8,
  parameter int N_LANE   = 4,
  parameter int SAMPLE_W = 10,
  parameter int ADDR_W   = 26
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                write_req,
  input  logic                                read_req,
  input  logic [31:0]                         data_write,
  output logic [31:0]                         data_read,
  input  logic [ADDR_W-1:0]                   addr,
  output logic                                busy,
  output logic [N_CHAN-1:0]                   read_enable,
  output logic [N_CHAN-1:0]                   buffer_rdreq,
  input  logic [N_CHAN-1:0]                   buffer_empty,
  input  logic [N_CHAN*N_LANE*SAMPLE_W-1:0]   buffer_data
);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_CHAN   = 3'd1;
  localparam logic [2:0] A_SEL    = 3'd2;
  localparam logic [2:0] A_STATUS = 3'd3;
  localparam logic [2:0] A_CNT    = 3'd4;
  localparam logic [2:0] A_DATA   = 3'd5;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REG_ACK  = 3'd1,
    DATA_CHK = 3'd2,
    DATA_POP = 3'd3,
    ACK      = 3'd4
  } state_t;

  state_t state, state_next;

  logic              run;
  logic [N_CHAN-1:0] chan_en;
  logic [7:0]        sel_chan;
  logic [3:0]        sel_lane;
  logic [31:0]       sample_cnt;
  logic              err_collide;
  logic              err_overrun;

  logic [2:0]        reg_addr;
  logic [31:0]       reg_rdata;
  logic [255:0]      en_ext;
  logic [255:0]      empty_ext;
  logic              data_valid;
  logic              lane_last;
  logic [SAMPLE_W-1:0] sample_sel;
  logic [15:0]       sample_ext;
  logic [31:0]       data_word;
  logic [N_CHAN-1:0] pop_mask;

  assign reg_addr = addr[2:0];

  // Widening the enable/empty vectors to the full 8-bit select range makes an
  // out-of-range channel look disabled and empty without a separate compare.
  assign en_ext     = 256'(chan_en);
  assign empty_ext  = {{(256-N_CHAN){1'b1}}, buffer_empty};
  assign data_valid = en_ext[sel_chan] & ~empty_ext[sel_chan];
  assign lane_last  = (sel_lane == 4'(N_LANE-1));

  always_comb begin
    sample_sel = '0;
    pop_mask   = '0;
    for (int c = 0; c < N_CHAN; c++) begin
      if (sel_chan == 8'(c)) begin
        pop_mask[c] = 1'b1;
        for (int l = 0; l < N_LANE; l++) begin
          if (sel_lane == 4'(l))
            sample_sel = buffer_data[(c*N_LANE+l)*SAMPLE_W +: SAMPLE_W];
        end
      end
    end
  end

  always_comb begin
    sample_ext = '0;
    sample_ext[SAMPLE_W-1:0] = sample_sel;
  end

  assign data_word = {1'b1, 3'b000, sel_lane, sel_chan, sample_ext};

  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      A_CTRL:   reg_rdata[0] = run;
      A_CHAN:   reg_rdata[N_CHAN-1:0] = chan_en;
      A_SEL: begin
        reg_rdata[7:0]  = sel_chan;
        reg_rdata[11:8] = sel_lane;
      end
      A_STATUS: begin
        reg_rdata[N_CHAN-1:0] = ~buffer_empty;
        reg_rdata[29]         = err_overrun;
        reg_rdata[30]         = err_collide;
        reg_rdata[31]         = run;
      end
      A_CNT:    reg_rdata = sample_cnt;
      default:  reg_rdata = '0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (write_req)
          state_next = REG_ACK;
        else if (read_req)
          state_next = (reg_addr == A_DATA) ? DATA_CHK : REG_ACK;
      end
      REG_ACK:  state_next = IDLE;
      DATA_CHK: state_next = (data_valid && lane_last) ? DATA_POP : ACK;
      DATA_POP: state_next = ACK;
      ACK:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // FSM outputs: the pop is decoded straight from the state so a reset that
  // lands before DATA_POP can never produce a stray pulse.
  always_comb begin
    buffer_rdreq = '0;
    if (state == DATA_POP) buffer_rdreq = pop_mask;
  end

  // Registers and datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_read   <= '0;
      busy        <= 1'b0;
      read_enable <= '0;
      run         <= 1'b0;
      chan_en     <= '0;
      sel_chan    <= '0;
      sel_lane    <= '0;
      sample_cnt  <= '0;
      err_collide <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      busy        <= (state_next != IDLE);
      read_enable <= chan_en & {N_CHAN{run}};

      if ((state != IDLE) && (write_req || read_req))
        err_overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (write_req) begin
            case (reg_addr)
              A_CTRL: begin
                run <= data_write[0];
                if (data_write[1]) begin
                  sample_cnt  <= '0;
                  err_collide <= 1'b0;
                  err_overrun <= 1'b0;
                end
              end
              A_CHAN: chan_en <= data_write[N_CHAN-1:0];
              A_SEL: begin
                // Selecting a new channel abandons any partially read word.
                sel_chan <= data_write[7:0];
                sel_lane <= '0;
              end
              default: ;
            endcase
            // Placed after the write so a collision is still recorded even
            // when the same write clears the flags.
            if (read_req) err_collide <= 1'b1;
          end else if (read_req && (reg_addr != A_DATA)) begin
            data_read <= reg_rdata;
          end
        end
        DATA_CHK: begin
          if (data_valid) begin
            data_read <= data_word;
            if (sample_cnt != 32'hFFFF_FFFF)
              sample_cnt <= sample_cnt + 32'd1;
            if (lane_last) sel_lane <= '0;
            else           sel_lane <= sel_lane + 4'd1;
          end else begin
            data_read <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_readout_ctrl.sv
module tb_adc_readout_ctrl;

  localparam int N_CHAN   = 8;
  localparam int N_LANE   = 4;
  localparam int SAMPLE_W = 10;
  localparam int ADDR_W   = 26;

  logic                              clk = 1'b0;
  logic                              reset = 1'b1;
  logic                              write_req = 1'b0;
  logic                              read_req = 1'b0;
  logic [31:0]                       data_write = '0;
  logic [31:0]                       data_read;
  logic [ADDR_W-1:0]                 addr = '0;
  logic                              busy;
  logic [N_CHAN-1:0]                 read_enable;
  logic [N_CHAN-1:0]                 buffer_rdreq;
  logic [N_CHAN-1:0]                 buffer_empty = '1;
  logic [N_CHAN*N_LANE*SAMPLE_W-1:0] buffer_data = '0;

  int n_cmp = 0;
  int n_err = 0;
  int rdreq_pulses = 0;
  int multi_hot = 0;
  logic [N_CHAN-1:0] rdreq_last = '0;

  logic [31:0] rd;
  int          bcyc;

  adc_readout_ctrl #(
    .N_CHAN(N_CHAN), .N_LANE(N_LANE), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .reset(reset), .write_req(write_req), .read_req(read_req),
    .data_write(data_write), .data_read(data_read), .addr(addr), .busy(busy),
    .read_enable(read_enable), .buffer_rdreq(buffer_rdreq),
    .buffer_empty(buffer_empty), .buffer_data(buffer_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (buffer_rdreq != '0) begin
      rdreq_pulses++;
      rdreq_last = buffer_rdreq;
    end
    if ($countones(buffer_rdreq) > 1) multi_hot++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy) cyc++;
      else break;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    int c;
    @(posedge clk); #1;
    addr = ADDR_W'(a); data_write = d; write_req = 1'b1;
    @(posedge clk); #1;
    write_req = 1'b0;
    wait_idle(c);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d, output int c);
    @(posedge clk); #1;
    addr = ADDR_W'(a); read_req = 1'b1;
    @(posedge clk); #1;
    read_req = 1'b0;
    wait_idle(c);
    d = data_read;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data_read", data_read, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'h0);
    chk("rst_read_enable", {24'd0, read_enable}, 32'h0);
    chk("rst_rdreq", {24'd0, buffer_rdreq}, 32'h0);
    reset = 1'b0;

    // STATUS with all FIFOs empty, busy for exactly one cycle
    bus_read(3'd3, rd, bcyc);
    chk("status_empty", rd, 32'h0000_0000);
    chk("reg_busy_cycles", 32'(bcyc), 32'd1);

    // run, then channel enables with a one-cycle lag on read_enable
    bus_write(3'd0, 32'h1);
    @(posedge clk); #1;
    addr = ADDR_W'(1); data_write = 32'h05; write_req = 1'b1;
    @(posedge clk); #1;
    write_req = 1'b0;
    chk("re_lag0", {24'd0, read_enable}, 32'h00);
    @(posedge clk); #1;
    chk("re_lag1", {24'd0, read_enable}, 32'h05);
    bus_read(3'd3, rd, bcyc);
    chk("status_run", rd, 32'h8000_0000);

    // channel 2 head word, lanes read one by one
    buffer_data[(2*N_LANE+0)*SAMPLE_W +: SAMPLE_W] = 10'h3FF;
    buffer_data[(2*N_LANE+1)*SAMPLE_W +: SAMPLE_W] = 10'h001;
    buffer_data[(2*N_LANE+2)*SAMPLE_W +: SAMPLE_W] = 10'h155;
    buffer_data[(2*N_LANE+3)*SAMPLE_W +: SAMPLE_W] = 10'h2AA;
    buffer_data[(3*N_LANE+0)*SAMPLE_W +: SAMPLE_W] = 10'h123;
    buffer_empty = 8'hFB;
    bus_write(3'd2, 32'h2);

    bus_read(3'd5, rd, bcyc);
    chk("data_l0", rd, 32'h8002_03FF);
    chk("data_busy_nopop", 32'(bcyc), 32'd2);
    chk("rdreq_after_l0", 32'(rdreq_pulses), 32'd0);
    bus_read(3'd5, rd, bcyc);
    chk("data_l1", rd, 32'h8102_0001);
    bus_read(3'd2, rd, bcyc);
    chk("sel_lane2", rd, 32'h0000_0202);
    bus_read(3'd5, rd, bcyc);
    chk("data_l2", rd, 32'h8202_0155);
    chk("rdreq_after_l2", 32'(rdreq_pulses), 32'd0);
    bus_read(3'd5, rd, bcyc);
    chk("data_l3", rd, 32'h8302_02AA);
    chk("data_busy_pop", 32'(bcyc), 32'd3);
    chk("rdreq_after_l3", 32'(rdreq_pulses), 32'd1);
    chk("rdreq_chan", {24'd0, rdreq_last}, 32'h04);
    bus_read(3'd4, rd, bcyc);
    chk("cnt_4", rd, 32'd4);
    bus_read(3'd2, rd, bcyc);
    chk("sel_lane_wrap", rd, 32'h0000_0002);

    // invalid selections: disabled, enabled-but-empty, out of range
    bus_write(3'd2, 32'h1);
    bus_read(3'd5, rd, bcyc);
    chk("data_disabled", rd, 32'h0);
    bus_write(3'd2, 32'h0);
    bus_read(3'd5, rd, bcyc);
    chk("data_empty", rd, 32'h0);
    bus_write(3'd2, 32'h9);
    bus_read(3'd5, rd, bcyc);
    chk("data_out_of_range", rd, 32'h0);
    chk("rdreq_invalid", 32'(rdreq_pulses), 32'd1);
    bus_read(3'd4, rd, bcyc);
    chk("cnt_unchanged", rd, 32'd4);

    // write/read collision
    @(posedge clk); #1;
    addr = ADDR_W'(1); data_write = 32'hFF; write_req = 1'b1; read_req = 1'b1;
    @(posedge clk); #1;
    write_req = 1'b0; read_req = 1'b0;
    wait_idle(bcyc);
    bus_read(3'd1, rd, bcyc);
    chk("chan_en_collide", rd, 32'h0000_00FF);
    bus_read(3'd3, rd, bcyc);
    chk("status_collide", rd, 32'hC000_0004);

    // request while busy
    @(posedge clk); #1;
    addr = ADDR_W'(3); read_req = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    read_req = 1'b0;
    wait_idle(bcyc);
    bus_read(3'd3, rd, bcyc);
    chk("status_overrun", rd, 32'hE000_0004);

    // clear flags and counter, run stays set
    bus_write(3'd0, 32'h3);
    bus_read(3'd3, rd, bcyc);
    chk("status_cleared", rd, 32'h8000_0004);
    bus_read(3'd4, rd, bcyc);
    chk("cnt_cleared", rd, 32'd0);
    bus_read(3'd0, rd, bcyc);
    chk("ctrl_readback", rd, 32'h1);

    // reset while the last-lane read is heading for a pop
    bus_write(3'd2, 32'h2);
    for (int i = 0; i < 3; i++) bus_read(3'd5, rd, bcyc);
    chk("data_l2_again", rd, 32'h8202_0155);
    bus_read(3'd2, rd, bcyc);
    chk("sel_lane3", rd, 32'h0000_0302);
    @(posedge clk); #1;
    addr = ADDR_W'(5); read_req = 1'b1;
    @(posedge clk); #1;
    read_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'h0);
    chk("mid_rst_data_read", data_read, 32'h0);
    chk("mid_rst_read_enable", {24'd0, read_enable}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_rdreq", {24'd0, buffer_rdreq}, 32'h0);
    reset = 1'b0;
    chk("rdreq_no_pop", 32'(rdreq_pulses), 32'd1);
    bus_read(3'd2, rd, bcyc);
    chk("sel_after_rst", rd, 32'h0);
    bus_read(3'd4, rd, bcyc);
    chk("cnt_after_rst", rd, 32'h0);
    bus_read(3'd0, rd, bcyc);
    chk("ctrl_after_rst", rd, 32'h0);
    chk("rdreq_onehot", 32'(multi_hot), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
